// File: rtl/snoopy_draw.sv
// snoopy_draw: redraws a fixed-column sprite whenever a frame tick brings a
// new vertical position. A move erases the old image (BG_COLOUR), then draws
// the new one (SNOOPY_COLOUR), one pixel per cycle in raster order. Rows at or
// below SCREEN_H still use their cycle but are not plotted.
//
// Ports
//   clock       sole clock, posedge
//   reset       synchronous, active-low
//   frame_tick  one-cycle redraw request, ignored while busy
//   snoopy_y    sprite top row, captured only on an accepted tick
//   vga_x       pixel column (registered)
//   vga_y       pixel row (registered)
//   vga_colour  pixel colour (registered)
//   plot        pixel write strobe (registered)
//   busy        redraw in progress (registered)
//   done        one-cycle completion pulse (registered)
module snoopy_draw #(
  parameter int unsigned SPRITE_W      = 16,
  parameter int unsigned SPRITE_H      = 16,
  parameter int unsigned SNOOPY_X      = 20,
  parameter logic [2:0]  SNOOPY_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR     = 3'b000,
  parameter int unsigned SCREEN_H      = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [6:0] snoopy_y,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int unsigned PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam logic [PXW-1:0] PX_LAST = PXW'(SPRITE_W - 1);
  localparam logic [PYW-1:0] PY_LAST = PYW'(SPRITE_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    ERASE,
    DRAW,
    FINISH
  } state_t;

  state_t         r_state;
  state_t         w_nx_state;
  logic [PXW-1:0] r_px;
  logic [PYW-1:0] r_py;
  logic [PXW-1:0] w_nx_px;
  logic [PYW-1:0] w_nx_py;
  logic [6:0]     r_new_y;
  logic [6:0]     w_nx_new_y;
  logic [6:0]     r_drawn_y;
  logic           r_drawn_valid;
  logic           w_last;
  logic           w_pixel;
  logic [6:0]     w_base;
  logic [7:0]     w_sum;

  logic [7:0]     r_vga_x;
  logic [6:0]     r_vga_y;
  logic [2:0]     r_vga_colour;
  logic           r_plot;
  logic           r_busy;
  logic           r_done;

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nx_state;
  end

  // Next state and next counter values. The output registers are loaded from
  // the pixel being entered, so the first pixel appears the cycle after the
  // tick edge and ERASE flows into DRAW without a gap.
  always_comb begin
    w_nx_state = r_state;
    w_nx_px    = r_px;
    w_nx_py    = r_py;
    w_nx_new_y = r_new_y;
    w_last     = (r_px == PX_LAST) && (r_py == PY_LAST);

    case (r_state)
      IDLE: begin
        if (frame_tick) begin
          w_nx_new_y = snoopy_y;
          w_nx_px    = '0;
          w_nx_py    = '0;
          if (r_drawn_valid && (snoopy_y == r_drawn_y)) w_nx_state = FINISH;
          else if (r_drawn_valid)                       w_nx_state = ERASE;
          else                                          w_nx_state = DRAW;
        end
      end
      ERASE, DRAW: begin
        if (w_last) begin
          w_nx_state = (r_state == ERASE) ? DRAW : FINISH;
          w_nx_px    = '0;
          w_nx_py    = '0;
        end else if (r_px == PX_LAST) begin
          w_nx_px = '0;
          w_nx_py = r_py + PYW'(1);
        end else begin
          w_nx_px = r_px + PXW'(1);
        end
      end
      FINISH: w_nx_state = IDLE;
      default: w_nx_state = IDLE;
    endcase

    w_pixel = (w_nx_state == ERASE) || (w_nx_state == DRAW);
    w_base  = (w_nx_state == ERASE) ? r_drawn_y : w_nx_new_y;
    w_sum   = {1'b0, w_base} + 8'(w_nx_py);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_px          <= '0;
      r_py          <= '0;
      r_new_y       <= '0;
      r_drawn_y     <= '0;
      r_drawn_valid <= 1'b0;
      r_vga_x       <= '0;
      r_vga_y       <= '0;
      r_vga_colour  <= '0;
      r_plot        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_px    <= w_nx_px;
      r_py    <= w_nx_py;
      r_new_y <= w_nx_new_y;
      if ((r_state == DRAW) && w_last) begin
        r_drawn_y     <= r_new_y;
        r_drawn_valid <= 1'b1;
      end
      r_plot <= w_pixel && (w_sum < 8'(SCREEN_H));
      if (w_pixel) begin
        r_vga_x      <= 8'(SNOOPY_X) + 8'(w_nx_px);
        r_vga_y      <= w_base + 7'(w_nx_py);
        r_vga_colour <= (w_nx_state == ERASE) ? BG_COLOUR : SNOOPY_COLOUR;
      end
      r_done <= (w_nx_state == FINISH);
      r_busy <= (w_nx_state != IDLE);
    end
  end

endmodule

// File: doc/snoopy_draw.md
SNOOPY_DRAW -- requirements
Module: snoopy_draw

Interface
REQ-001 Parameters SHALL be as follows.
- SPRITE_W, 16, sprite width in pixels.
- SPRITE_H, 16, sprite height in pixels.
- SNOOPY_X, 20, fixed left column of the sprite.
- SNOOPY_COLOUR, 3'b111, sprite draw colour.
- BG_COLOUR, 3'b000, erase colour.
- SCREEN_H, 120, number of visible rows.

REQ-002 Ports SHALL be as follows.
- clock  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- frame_tick  input  1  one-cycle redraw request.
- snoopy_y  input  7  sprite top row from the vertical FSM; sampled only on an accepted tick.
- vga_x  output  8  pixel column.
- vga_y  output  7  pixel row.
- vga_colour  output  3  pixel colour.
- plot  output  1  pixel write strobe to the VGA adapter.
- busy  output  1  redraw in progress.
- done  output  1  one-cycle pulse when a redraw completes.

REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have states IDLE, ERASE, DRAW and FINISH.
REQ-005 In IDLE, frame_tick=1 SHALL be accepted and the block SHALL capture new_y = snoopy_y.
REQ-006 On an accepted tick, the block SHALL go to FINISH if drawn_valid=1 and new_y == drawn_y.
REQ-007 Otherwise it SHALL go to ERASE if drawn_valid=1, else to DRAW.
REQ-008 On entry to ERASE or DRAW, counters px and py SHALL be cleared to 0.
REQ-009 ERASE and DRAW SHALL emit exactly one pixel per cycle in raster order: px increments first, and on wrap at SPRITE_W-1 px returns to 0 and py increments.
REQ-010 Per pixel, outputs SHALL be vga_x = SNOOPY_X + px (8-bit) and vga_y = base + py.
- base = drawn_y in ERASE, new_y in DRAW.
- vga_colour = BG_COLOUR in ERASE, SNOOPY_COLOUR in DRAW.
REQ-011 plot SHALL be 1 for a pixel only if base + py, computed 8 bits wide, is < SCREEN_H; a clipped pixel SHALL still consume its cycle with plot=0.
REQ-012 Pixel timing:
- ERASE pixels occupy SPRITE_W*SPRITE_H consecutive cycles, starting the cycle after the tick edge.
- DRAW pixels immediately follow, with no gap.
REQ-013 After the last DRAW pixel, the block SHALL set drawn_y = new_y and drawn_valid=1, then enter FINISH.
REQ-014 FINISH SHALL last one cycle with done=1 and plot=0, then return to IDLE.
REQ-015 busy SHALL be 1 from the cycle after an accepted tick through the FINISH cycle inclusive, and 0 otherwise.
REQ-016 frame_tick SHALL be ignored while busy=1; no queuing.
REQ-017 snoopy_y changes during a redraw SHALL have no effect on that redraw.
REQ-018 Outside ERASE and DRAW, plot SHALL be 0.
REQ-019 Outside ERASE and DRAW, vga_x, vga_y and vga_colour SHALL hold their last values.
REQ-020 Latency from tick to done:
- 1 cycle for an unchanged y.
- 2*W*H + 1 cycles for a move.
- W*H + 1 cycles for the first draw after reset.

Reset
REQ-021 On reset=0 at a clock edge, the block SHALL clear the following, with no partial-frame continuation:
- state = IDLE.
- plot=0, done=0, busy=0.
- vga_x=0, vga_y=0, vga_colour=0.
- px=py=0.
- drawn_y=0, drawn_valid=0.
REQ-022 Reset mid-ERASE or mid-DRAW SHALL drop plot to 0 at that edge, and the next accepted tick SHALL perform DRAW only, with no ERASE.

Verification (bench parameters W=H=4, SNOOPY_X=20)
REQ-023 First draw: reset, then tick with snoopy_y=100 ->
- 16 plots, x 20..23, y 100..103, colour 7, no erase.
- done pulse 17 cycles after the tick.
REQ-024 Move: then tick with snoopy_y=80 ->
- 16 plots at y 100..103, colour 0.
- Then 16 plots at y 80..83, colour 7.
- done at cycle 33; busy high for cycles 1..33.
REQ-025 No move: tick again with snoopy_y=80 -> zero plots; done and busy high for exactly cycle 1.
REQ-026 Clip: tick with snoopy_y=118 ->
- erase rows 80..83.
- Draw rows 118..119 with plot=1, rows 120..121 with plot=0.
- Still 16 draw cycles.
REQ-027 Busy ignore: a tick at cycle 5 of a redraw, with snoopy_y=50 -> no restart; drawn_y stays at the originally captured value.
REQ-028 Reset mid-DRAW (cycle 8), then tick with snoopy_y=60 -> plot=0 at the reset edge; next redraw is 16 draw pixels only, rows 60..63.
